// File: rtl/formation_mover_if.sv
// formation_mover_if
//   Bundles the game-control <-> formation_mover signals.
//   master : game-control side (drives frame tick, mode, turbo, restart,
//            alive count and live-column extents; observes position/status)
//   slave  : formation_mover side
// Ports (all carried as interface members):
//   startOfFrame  one-cycle frame tick
//   isGameMode    motion enable
//   turbo         speed multiplier enable
//   restart       one-cycle reload pulse
//   aliveCount    live alien count (CNT_W bits)
//   liveLeftPx    offset of leftmost live pixel from topLeftX
//   liveRightPx   offset of rightmost live pixel from topLeftX
//   topLeftX/Y    signed integer pixel position of the formation corner
//   movingRight   formation is heading (or about to head) right
//   dropping      formation is in a drop phase
//   edgeHit       one-cycle pulse after a tick that started a drop
//   landed        sticky game-over flag
interface formation_mover_if #(
  parameter int CNT_W = 6
);
  logic             startOfFrame;
  logic             isGameMode;
  logic             turbo;
  logic             restart;
  logic [CNT_W-1:0] aliveCount;
  logic [10:0]      liveLeftPx;
  logic [10:0]      liveRightPx;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic             movingRight;
  logic             dropping;
  logic             edgeHit;
  logic             landed;

  modport master (
    output startOfFrame, isGameMode, turbo, restart,
           aliveCount, liveLeftPx, liveRightPx,
    input  topLeftX, topLeftY, movingRight, dropping, edgeHit, landed
  );

  modport slave (
    input  startOfFrame, isGameMode, turbo, restart,
           aliveCount, liveLeftPx, liveRightPx,
    output topLeftX, topLeftY, movingRight, dropping, edgeHit, landed
  );
endinterface

// File: rtl/formation_mover.sv
// formation_mover
//   Steps the alien formation's top-left corner right -> down -> left ->
//   down once per frame tick, in fixed point with FRAC_BITS fraction bits.
//   Edge detection uses the extents of the still-alive columns so the
//   formation reaches the true screen edges as columns die. A drop whose
//   target reaches BOTTOM_LIMIT ends the game (sticky landed flag) until
//   restart or reset.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high
//   bus    formation_mover_if.slave (see interface header for members);
//          the interface CNT_W must match this module's CNT_W
// Configuration:
//   FORMATION_SPEEDUP_EN  when defined, speed grows by SPEEDUP_STEP per
//                         dead alien (MAX_ALIENS - aliveCount) before the
//                         turbo multiply; otherwise aliveCount is ignored.
module formation_mover #(
  parameter int FRAC_BITS      = 6,
  parameter int INITIAL_X      = 40,
  parameter int INITIAL_Y      = 40,
  parameter int LEFT_BOUNDARY  = 40,
  parameter int RIGHT_BOUNDARY = 599,
  parameter int Y_GAP          = 8,
  parameter int BOTTOM_LIMIT   = 400,
  parameter int SPEED_BASE     = 32,
  parameter int TURBO_MUL      = 10,
  parameter int MAX_ALIENS     = 40,
  parameter int SPEEDUP_STEP   = 4,
  parameter int SPEED_MAX      = 640,
  parameter int CNT_W          = 6
) (
  input logic              clk,
  input logic              reset,
  formation_mover_if.slave bus
);

  localparam int W         = 11 + FRAC_BITS;
  localparam int INIT_X_FX = INITIAL_X << FRAC_BITS;
  localparam int INIT_Y_FX = INITIAL_Y << FRAC_BITS;
  localparam int LEFT_FX   = LEFT_BOUNDARY << FRAC_BITS;
  localparam int RIGHT_FX  = RIGHT_BOUNDARY << FRAC_BITS;
  localparam int GAP_FX    = Y_GAP << FRAC_BITS;
  localparam int BOTTOM_FX = BOTTOM_LIMIT << FRAC_BITS;

  typedef enum logic [2:0] {
    MOVE_RIGHT,
    DROP_TO_LEFT,
    MOVE_LEFT,
    DROP_TO_RIGHT,
    LANDED
  } state_t;

  state_t              state;
  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic signed [W-1:0] drop_target;
  logic                moving_right;
  logic                dropping;
  logic                edge_hit;
  logic                landed;

  logic [CNT_W-1:0]    alive_bits;
  logic                tick;
  int                  base_speed;
  int                  speed;

  assign alive_bits = bus.aliveCount;
  assign tick       = bus.startOfFrame && bus.isGameMode && !landed;

`ifdef FORMATION_SPEEDUP_EN
  // Each dead alien adds SPEEDUP_STEP; a count above MAX_ALIENS is
  // treated as nobody dead rather than a negative speed-up.
  always_comb begin
    int alive_n;
    int dead_n;
    alive_n    = int'(alive_bits);
    dead_n     = (alive_n > MAX_ALIENS) ? 0 : (MAX_ALIENS - alive_n);
    base_speed = SPEED_BASE + dead_n * SPEEDUP_STEP;
  end
`else
  logic unused_alive;
  assign unused_alive = ^alive_bits;
  assign base_speed   = SPEED_BASE;
`endif

  // Turbo multiplies the (possibly sped-up) base, then the result is clamped.
  always_comb begin
    int turbo_speed;
    turbo_speed = bus.turbo ? (base_speed * TURBO_MUL) : base_speed;
    speed       = (turbo_speed > SPEED_MAX) ? SPEED_MAX : turbo_speed;
  end

  // Candidate positions and edge tests, all in the fixed-point scale and
  // widened to 32 bits so the compares never wrap.
  int   x_step_r;
  int   x_step_l;
  int   x_clamp_r;
  int   x_clamp_l;
  int   y_step;
  int   target_next;
  logic hit_right;
  logic hit_left;
  logic drop_done;
  logic lands;

  always_comb begin
    int right_off;
    int left_off;
    right_off   = int'(bus.liveRightPx) << FRAC_BITS;
    left_off    = int'(bus.liveLeftPx) << FRAC_BITS;
    x_step_r    = int'(x) + speed;
    x_step_l    = int'(x) - speed;
    hit_right   = (x_step_r + right_off) >= RIGHT_FX;
    hit_left    = (x_step_l + left_off) <= LEFT_FX;
    x_clamp_r   = RIGHT_FX - right_off;
    x_clamp_l   = LEFT_FX - left_off;
    y_step      = int'(y) + speed;
    drop_done   = y_step >= int'(drop_target);
    target_next = int'(y) + GAP_FX;
    lands       = target_next >= BOTTOM_FX;
  end

  // Movement FSM. Restart shares the reset path so it also beats a
  // simultaneous tick. edge_hit defaults low so it is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset || bus.restart) begin
      state        <= MOVE_RIGHT;
      x            <= W'(INIT_X_FX);
      y            <= W'(INIT_Y_FX);
      drop_target  <= W'(INIT_Y_FX);
      moving_right <= 1'b1;
      dropping     <= 1'b0;
      edge_hit     <= 1'b0;
      landed       <= 1'b0;
    end else begin
      edge_hit <= 1'b0;
      if (tick) begin
        case (state)
          MOVE_RIGHT: begin
            if (hit_right) begin
              x           <= W'(x_clamp_r);
              drop_target <= W'(target_next);
              moving_right <= 1'b0;
              if (lands) begin
                state  <= LANDED;
                landed <= 1'b1;
              end else begin
                state    <= DROP_TO_LEFT;
                dropping <= 1'b1;
                edge_hit <= 1'b1;
              end
            end else begin
              x <= W'(x_step_r);
            end
          end

          DROP_TO_LEFT: begin
            if (drop_done) begin
              y        <= drop_target;
              state    <= MOVE_LEFT;
              dropping <= 1'b0;
            end else begin
              y <= W'(y_step);
            end
          end

          MOVE_LEFT: begin
            if (hit_left) begin
              x           <= W'(x_clamp_l);
              drop_target <= W'(target_next);
              if (lands) begin
                state        <= LANDED;
                landed       <= 1'b1;
                moving_right <= 1'b0;
              end else begin
                state        <= DROP_TO_RIGHT;
                moving_right <= 1'b1;
                dropping     <= 1'b1;
                edge_hit     <= 1'b1;
              end
            end else begin
              x <= W'(x_step_l);
            end
          end

          DROP_TO_RIGHT: begin
            if (drop_done) begin
              y        <= drop_target;
              state    <= MOVE_RIGHT;
              dropping <= 1'b0;
            end else begin
              y <= W'(y_step);
            end
          end

          default: begin
            state <= LANDED;
          end
        endcase
      end
    end
  end

  // Arithmetic shift of a signed value: the upper bits are the floor.
  assign bus.topLeftX    = x[W-1:FRAC_BITS];
  assign bus.topLeftY    = y[W-1:FRAC_BITS];
  assign bus.movingRight = moving_right;
  assign bus.dropping    = dropping;
  assign bus.edgeHit     = edge_hit;
  assign bus.landed      = landed;

endmodule
